// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan-capture path.
// Optional parity output is enabled in the top with MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

    localparam int SETTLE_CNT_W = 4;
    localparam int DEF_SEL_W    = 2;
    localparam int DEF_SETTLE   = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mux_scan_capture_settle_timer.sv
// Loadable down-counter; done flags the final settle cycle of a channel.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int W = SETTLE_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_r;

    // load has priority over decrement; counter parks at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == W'(1));

endmodule

// File: rtl/mux_scan_capture.sv
// Steps the selector through every channel, samples y_in after a settle window
// and presents the word over valid/ready. Define MUX_SCAN_PARITY_EN for parity.
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int SEL_W  = DEF_SEL_W,
    parameter int SETTLE = DEF_SETTLE,
    localparam int N     = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [SEL_W-1:0] sel,
    input  logic             y_in,
    output logic             busy,
    output logic [N-1:0]     word,
    output logic             valid,
    input  logic             ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [SEL_W-1:0]        SEL_LAST = SEL_W'(N - 1);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LD = SETTLE_CNT_W'(SETTLE);

    scan_state_t      state_r, state_n;
    logic [SEL_W-1:0] sel_r, sel_n;
    logic [N-1:0]     word_r, word_n;
    logic             valid_r, valid_n;
    logic             busy_r, busy_n;
    logic             parity_r, parity_n;
    logic             load_s, dec_s, done_s;

    settle_timer #(.W(SETTLE_CNT_W)) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (SETTLE_LD),
        .en       (dec_s),
        .done     (done_s)
    );

    // Next-state and next-output logic for the scan FSM
    always_comb begin
        state_n  = state_r;
        sel_n    = sel_r;
        word_n   = word_r;
        valid_n  = valid_r;
        busy_n   = busy_r;
        parity_n = parity_r;
        load_s   = 1'b0;
        dec_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sel_n  = {SEL_W{1'b0}};
                    word_n = {N{1'b0}};
                    busy_n = 1'b1;
                    if (SETTLE == 0) begin
                        state_n = ST_SAMPLE;
                    end else begin
                        state_n = ST_SETTLE;
                        load_s  = 1'b1;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                dec_s = 1'b1;
                if (done_s) begin
                    state_n = ST_SAMPLE;
                end else begin
                    state_n = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                word_n[sel_r] = y_in;
                if (sel_r == SEL_LAST) begin
                    state_n  = ST_HOLD;
                    valid_n  = 1'b1;
                    parity_n = ^word_n;
                end else begin
                    sel_n = sel_r + SEL_W'(1);
                    if (SETTLE == 0) begin
                        state_n = ST_SAMPLE;
                    end else begin
                        state_n = ST_SETTLE;
                        load_s  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (valid_r && ready) begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    sel_n   = {SEL_W{1'b0}};
                end else begin
                    state_n = ST_HOLD;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                sel_n   = {SEL_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sel_r    <= {SEL_W{1'b0}};
            word_r   <= {N{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            parity_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            sel_r    <= sel_n;
            word_r   <= word_n;
            valid_r  <= valid_n;
            busy_r   <= busy_n;
            parity_r <= parity_n;
        end
    end

    assign sel   = sel_r;
    assign word  = word_r;
    assign valid = valid_r;
    assign busy  = busy_r;
`ifdef MUX_SCAN_PARITY_EN
    assign parity = parity_r;
`endif

endmodule

// File: tb/tb_mux_scan_capture.sv
// Bench for mux_scan_capture: three instances (SETTLE 1, 0, 3) each feeding a
// 4:1 selector model; results compared against a channel/latency reference.
module tb_mux_scan_capture;

    logic       clk;
    logic       rst;
    logic       start_s [3];
    logic       ready_s [3];
    logic [1:0] sel_s   [3];
    logic [3:0] d_s     [3];
    logic [3:0] word_s  [3];
    logic       valid_s [3];
    logic       busy_s  [3];
    logic       y_s     [3];
`ifdef MUX_SCAN_PARITY_EN
    logic       parity_s [3];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int st(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign y_s[g] = d_s[g][sel_s[g]];

        mux_scan_capture #(
            .SEL_W  (2),
            .SETTLE ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_s[g]),
            .sel   (sel_s[g]),
            .y_in  (y_s[g]),
            .busy  (busy_s[g]),
            .word  (word_s[g]),
            .valid (valid_s[g]),
            .ready (ready_s[g])
`ifdef MUX_SCAN_PARITY_EN
            ,
            .parity (parity_s[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, "_sel"},   32'(sel_s[i]),   32'd0);
        check({tag, "_valid"}, 32'(valid_s[i]), 32'd0);
        check({tag, "_busy"},  32'(busy_s[i]),  32'd0);
    endtask

    // One complete scan on instance i with d=dv; ready held low for hold_cycles after valid.
    task automatic run_scan(input int i, input logic [3:0] dv, input int hold_cycles);
        int lat;
        int c;
        lat = 4 * (st(i) + 1);
        @(negedge clk);
        d_s[i]     = dv;
        start_s[i] = 1'b1;
        ready_s[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        c = 0;
        while (!valid_s[i] && c < 200) begin
            check("scan_sel", 32'(sel_s[i]), 32'(c / (st(i) + 1)));
            check("scan_busy", 32'(busy_s[i]), 32'd1);
            start_s[i] = 1'($urandom_range(0, 1));
            ready_s[i] = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            c = c + 1;
        end
        check("latency", 32'(c), 32'(lat));
        check("word", 32'(word_s[i]), 32'(dv));
        check("hold_sel", 32'(sel_s[i]), 32'd3);
`ifdef MUX_SCAN_PARITY_EN
        check("parity", 32'(parity_s[i]), 32'(^dv));
`endif
        ready_s[i] = 1'b0;
        for (int h = 0; h < hold_cycles; h++) begin
            d_s[i]     = 4'($urandom_range(0, 15));
            start_s[i] = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(valid_s[i]), 32'd1);
            check("hold_word", 32'(word_s[i]), 32'(dv));
        end
        ready_s[i] = 1'b1;
        start_s[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[i] = 1'b0;
        ready_s[i] = 1'b0;
        check_idle(i, "handshake");
        @(posedge clk);
        @(negedge clk);
        check("no_restart_busy", 32'(busy_s[i]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            ready_s[i] = 1'b0;
            d_s[i]     = 4'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_idle(i, "reset");
            check("reset_word", 32'(word_s[i]), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
            check("reset_parity", 32'(parity_s[i]), 32'd0);
`endif
        end
        rst = 1'b0;

        run_scan(0, 4'b1010, 0);
        run_scan(0, 4'h5, 5);
        run_scan(0, 4'b0111, 0);
        run_scan(0, 4'b0110, 1);
        for (int k = 0; k < 6; k++) begin
            run_scan(0, 4'($urandom_range(0, 15)), $urandom_range(0, 4));
        end
        for (int dv = 0; dv < 16; dv++) begin
            run_scan(1, 4'(dv), 0);
            run_scan(2, 4'(dv), $urandom_range(0, 2));
        end

        // abort mid-scan
        @(negedge clk);
        d_s[0]     = 4'hF;
        start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle(0, "abort");
        check("abort_word", 32'(word_s[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_idle(0, "abort_next");
        check("abort_next_word", 32'(word_s[0]), 32'd0);
        rst = 1'b0;
        run_scan(0, 4'hF, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
